param_shifter: RTL and testbench

//  Parametrised multi-mode word shift register: DEPTH stages of WIDTH-bit words.

---
 rtl/param_shifter_pkg.sv | 26 ++
 rtl/param_shifter_shift_cell.sv | 47 ++++
 rtl/param_shifter.sv | 108 ++++++++++
 tb/tb_param_shifter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/param_shifter_pkg.sv
// ----------------------------------------------------------------------------
//  shifter_pkg : shared types for the param_shifter word shift register
//  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package shifter_pkg;

    typedef enum logic [1:0] {
        SH_FWD  = 2'b00,
        SH_ROT  = 2'b01,
        SH_BWD  = 2'b10,
        SH_RSVD = 2'b11
    } shift_mode_e;

    // Next-value source for one stage register.
    typedef enum logic [1:0] {
        CELL_HOLD = 2'b00,
        CELL_PREV = 2'b01,
        CELL_NEXT = 2'b10,
        CELL_LOAD = 2'b11
    } cell_sel_e;

endpackage

`default_nettype wire

// File: rtl/param_shifter_shift_cell.sv
// ----------------------------------------------------------------------------
//  shift_cell : one WIDTH-bit stage with hold/prev/next/load next-value mux
//  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module shift_cell
    import shifter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  cell_sel_e        sel_i,
    input  logic [WIDTH-1:0] prev_i,
    input  logic [WIDTH-1:0] next_i,
    input  logic [WIDTH-1:0] load_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q;
    logic [WIDTH-1:0] stage_d;

    always_comb begin
        stage_d = stage_q;
        unique case (sel_i)
            CELL_HOLD: stage_d = stage_q;
            CELL_PREV: stage_d = prev_i;
            CELL_NEXT: stage_d = next_i;
            CELL_LOAD: stage_d = load_i;
            default:   stage_d = stage_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q;

endmodule

`default_nettype wire

// File: rtl/param_shifter.sv
// ----------------------------------------------------------------------------
//  param_shifter : DEPTH x WIDTH multi-mode word shift register with fill count
//  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module param_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         shn,
    input  logic [1:0]                   mode,
    input  logic                         ld,
    input  logic [DEPTH*WIDTH-1:0]       pdata,
    input  logic [WIDTH-1:0]             si,
    output logic [WIDTH-1:0]             so,
    output logic [DEPTH*WIDTH-1:0]       pout,
    output logic [$clog2(DEPTH+1)-1:0]   fill_cnt,
    output logic                         full
);

    localparam int FILL_W = $clog2(DEPTH + 1);

    shift_mode_e       w_mode;
    cell_sel_e         w_sel;
    logic              w_grow;
    logic [WIDTH-1:0]  w_stage [DEPTH];
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;

    assign w_mode = shift_mode_e'(mode);

    // One selector drives every stage: load beats shift, RSVD behaves as hold.
    always_comb begin
        w_sel  = CELL_HOLD;
        w_grow = 1'b0;
        if (ld) begin
            w_sel = CELL_LOAD;
        end else if (shn) begin
            unique case (w_mode)
                SH_FWD:  begin w_sel = CELL_PREV; w_grow = 1'b1; end
                SH_ROT:  w_sel = CELL_PREV;
                SH_BWD:  begin w_sel = CELL_NEXT; w_grow = 1'b1; end
                default: w_sel = CELL_HOLD;
            endcase
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        logic [WIDTH-1:0] w_prev;
        logic [WIDTH-1:0] w_next;

        if (g == 0) begin : g_head
            assign w_prev = (w_mode == SH_ROT) ? w_stage[DEPTH-1] : si;
        end else begin : g_head_body
            assign w_prev = w_stage[g-1];
        end

        if (g == DEPTH - 1) begin : g_tail
            assign w_next = si;
        end else begin : g_tail_body
            assign w_next = w_stage[g+1];
        end

        shift_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .sel_i  (w_sel),
            .prev_i (w_prev),
            .next_i (w_next),
            .load_i (pdata[g*WIDTH +: WIDTH]),
            .q_o    (w_stage[g])
        );

        assign pout[g*WIDTH +: WIDTH] = w_stage[g];
    end

    // Fill saturates at DEPTH; once full, shifting just drops the oldest word.
    always_comb begin
        fill_d = fill_q;
        if (ld) begin
            fill_d = FILL_W'(DEPTH);
        end else if (w_grow && !full) begin
            fill_d = fill_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign fill_cnt = fill_q;
    assign full     = (fill_q == FILL_W'(DEPTH));
    assign so       = (w_mode == SH_BWD) ? w_stage[0] : w_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: tb/tb_param_shifter.sv
// ----------------------------------------------------------------------------
//  tb_param_shifter : directed scoreboard bench for param_shifter (4 x 4)
//  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_param_shifter;
    import shifter_pkg::*;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int FW = $clog2(D + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            shn;
    logic [1:0]      mode;
    logic            ld;
    logic [D*W-1:0]  pdata;
    logic [W-1:0]    si;
    logic [W-1:0]    so;
    logic [D*W-1:0]  pout;
    logic [FW-1:0]   fill_cnt;
    logic            full;

    param_shifter #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .shn      (shn),
        .mode     (mode),
        .ld       (ld),
        .pdata    (pdata),
        .si       (si),
        .so       (so),
        .pout     (pout),
        .fill_cnt (fill_cnt),
        .full     (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   so;
        logic [D*W-1:0] pout;
        logic [FW-1:0]  fill;
        logic           full;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] m_stage [D];
    int           m_fill;
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the reference model, queue its prediction, then
    // compare the DUT against the popped prediction just after the edge.
    task automatic step(input string tag, input logic r, input logic l, input logic s,
                        input logic [1:0] m, input logic [D*W-1:0] pd, input logic [W-1:0] sin);
        exp_t         e;
        logic [W-1:0] tmp;
        rst = r; ld = l; shn = s; mode = m; pdata = pd; si = sin;
        if (r) begin
            for (int i = 0; i < D; i++) m_stage[i] = '0;
            m_fill = 0;
        end else if (l) begin
            for (int i = 0; i < D; i++) m_stage[i] = pd[i*W +: W];
            m_fill = D;
        end else if (s) begin
            case (m)
                2'b00: begin
                    for (int i = D - 1; i > 0; i--) m_stage[i] = m_stage[i-1];
                    m_stage[0] = sin;
                    if (m_fill < D) m_fill++;
                end
                2'b01: begin
                    tmp = m_stage[D-1];
                    for (int i = D - 1; i > 0; i--) m_stage[i] = m_stage[i-1];
                    m_stage[0] = tmp;
                end
                2'b10: begin
                    for (int i = 0; i < D - 1; i++) m_stage[i] = m_stage[i+1];
                    m_stage[D-1] = sin;
                    if (m_fill < D) m_fill++;
                end
                default: ;
            endcase
        end
        e.so = (m == 2'b10) ? m_stage[0] : m_stage[D-1];
        for (int i = 0; i < D; i++) e.pout[i*W +: W] = m_stage[i];
        e.fill = FW'(m_fill);
        e.full = (m_fill == D);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk({tag, "_sbq_empty"}, 64'd0, 64'd1);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_so"},   64'(so),       64'(e.so));
            chk({tag, "_pout"}, 64'(pout),     64'(e.pout));
            chk({tag, "_fill"}, 64'(fill_cnt), 64'(e.fill));
            chk({tag, "_full"}, 64'(full),     64'(e.full));
        end
    endtask

    initial begin
        logic [W-1:0] fwd_si  [4];
        logic [W-1:0] rot_exp [4];
        logic [W-1:0] bwd_si  [4];
        fwd_si  = '{4'hA, 4'h5, 4'hD, 4'h8};
        rot_exp = '{4'hD, 4'h5, 4'hA, 4'h8};
        bwd_si  = '{4'h1, 4'h2, 4'h3, 4'h4};
        rst = 1'b1; ld = 1'b0; shn = 1'b0; mode = SH_FWD; pdata = '0; si = '0;
        for (int i = 0; i < D; i++) m_stage[i] = '0;
        m_fill = 0;

        // Reset held with shifting requested
        for (int i = 0; i < 10; i++) step("rst", 1'b1, 1'b0, 1'b1, SH_FWD, '0, 4'hF);
        chk("rst_pout_const", 64'(pout), 64'h0);
        chk("rst_fill_const", 64'(fill_cnt), 64'h0);

        // Forward fill and overflow
        for (int i = 0; i < 4; i++) step("fwd", 1'b0, 1'b0, 1'b1, SH_FWD, '0, fwd_si[i]);
        chk("fwd_so_const",   64'(so),   64'hA);
        chk("fwd_pout_const", 64'(pout), 64'hA5D8);
        chk("fwd_full_const", 64'(full), 64'h1);
        step("fwd_ovf", 1'b0, 1'b0, 1'b1, SH_FWD, '0, 4'h3);
        chk("ovf_so_const",   64'(so),       64'h5);
        chk("ovf_fill_const", 64'(fill_cnt), 64'h4);

        // Hold while si/mode wander (so mux follows mode, registers must not move)
        for (int i = 0; i < 10; i++)
            step("hold", 1'b0, 1'b0, 1'b0, 2'(i % 4), '0, 4'(i * 3));
        chk("hold_pout_const", 64'(pout), 64'h5D83);
        step("rsvd", 1'b0, 1'b0, 1'b1, SH_RSVD, '0, 4'hE);
        chk("rsvd_pout_const", 64'(pout), 64'h5D83);

        // Parallel load then rotate
        step("ld", 1'b0, 1'b1, 1'b1, SH_BWD, 16'h8D5A, 4'h0);
        mode = SH_FWD;
        #1;
        chk("ld_so_const", 64'(so), 64'h8);
        for (int i = 0; i < 4; i++) begin
            step("rot", 1'b0, 1'b0, 1'b1, SH_ROT, '0, 4'hF);
            chk("rot_so_const",   64'(so),       64'(rot_exp[i]));
            chk("rot_fill_const", 64'(fill_cnt), 64'h4);
        end

        // Backward fill after reset
        step("rst2", 1'b1, 1'b0, 1'b0, SH_FWD, '0, 4'h0);
        for (int i = 0; i < 4; i++) step("bwd", 1'b0, 1'b0, 1'b1, SH_BWD, '0, bwd_si[i]);
        chk("bwd_so_const",   64'(so),   64'h1);
        chk("bwd_pout_const", 64'(pout), 64'h4321);
        chk("bwd_full_const", 64'(full), 64'h1);

        // Mode change mid-stream keeps contents
        step("mix_fwd", 1'b0, 1'b0, 1'b1, SH_FWD, '0, 4'h9);
        chk("mix_pout_const", 64'(pout), 64'h3219);

        // Reset beats load and shift on the same edge
        step("rst_ld", 1'b1, 1'b1, 1'b1, SH_FWD, 16'hFFFF, 4'hF);
        chk("rst_ld_pout_const", 64'(pout), 64'h0);
        step("post", 1'b0, 1'b0, 1'b1, SH_FWD, '0, 4'h7);
        chk("post_fill_const", 64'(fill_cnt), 64'h1);
        chk("post_pout_const", 64'(pout),     64'h0007);

        chk("sbq_drained", 64'(sbq.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
